fetch_stage: RTL and testbench

- Instruction-fetch stage of the pipelined processor simulator.
- Accepts the program body one instruction word per cycle from the program loader and stores it in an internal instruction memory.
- Once loading completes, walks a PC through that memory and presents instructions to decode over a valid/ready handshake.
- Supports branch redirect (flush) from execute and stops cleanly at the end of the program.

---
 rtl/fetch_stage_pkg.sv | 21 ++
 rtl/fetch_stage_imem.sv | 30 +++
 rtl/fetch_stage.sv | 154 +++++++++++++++
 tb/tb_fetch_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : proc_pkg                                                |
// | Brief    : Shared widths, types and fetch FSM states.              |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package proc_pkg;
  localparam int IW    = 32;
  localparam int DEPTH = 256;
  localparam int AW    = $clog2(DEPTH);

  typedef logic [IW-1:0] instr_t;
  typedef logic [AW-1:0] addr_t;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_e;
endpackage
`default_nettype wire

// File: rtl/fetch_stage_imem.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : imem                                                    |
// | Brief    : DEPTH x IW instruction store, one write port and an     |
// |            asynchronous read port; contents are never reset.       |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module imem #(
  parameter int IW    = proc_pkg::IW,
  parameter int DEPTH = proc_pkg::DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);
  logic [IW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];
endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : fetch_stage                                             |
// | Brief    : Loads a program into imem, then streams it to decode    |
// |            over valid/ready with branch redirect and end detect.   |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module fetch_stage #(
  parameter int IW    = proc_pkg::IW,
  parameter int DEPTH = proc_pkg::DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  input  logic [IW-1:0] load_data,
  input  logic          load_last,
  output logic          load_ready,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          out_valid,
  output logic [IW-1:0] out_instr,
  output logic [AW-1:0] out_pc,
  input  logic          out_ready,
  output logic [AW:0]   prog_len,
  output logic          load_err,
  output logic          done
);
  import proc_pkg::*;

  fetch_state_e  r_state;
  fetch_state_e  w_state_next;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_pc;
  logic [AW:0]   r_prog_len;
  logic          r_out_valid;
  logic [IW-1:0] r_out_instr;
  logic [AW-1:0] r_out_pc;
  logic          r_load_err;
  logic          r_done;

  logic          w_mem_we;
  logic          w_load_end;
  logic          w_load_ovf;
  logic          w_advance;
  logic          w_redirect;
  logic          w_fetch;
  logic          w_finish;
  logic [IW-1:0] w_rdata;

  imem #(
    .IW    (IW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_imem (
    .clk   (clk),
    .we    (w_mem_we),
    .waddr (r_wr_ptr),
    .wdata (load_data),
    .raddr (r_pc[AW-1:0]),
    .rdata (w_rdata)
  );

  assign w_advance = !r_out_valid || out_ready;

  always_comb begin
    w_state_next = r_state;
    w_mem_we     = 1'b0;
    w_load_end   = 1'b0;
    w_load_ovf   = 1'b0;
    w_redirect   = 1'b0;
    w_fetch      = 1'b0;
    w_finish     = 1'b0;
    load_ready   = 1'b0;
    case (r_state)
      LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          w_mem_we = 1'b1;
          if (load_last) begin
            w_load_end   = 1'b1;
            w_state_next = RUN;
          end else if (r_wr_ptr == AW'(DEPTH - 1)) begin
            w_load_end   = 1'b1;
            w_load_ovf   = 1'b1;
            w_state_next = RUN;
          end
        end
      end
      RUN: begin
        // Redirect beats both advance and stall: the word on out_* is dropped.
        if (redirect_valid) begin
          w_redirect = 1'b1;
        end else if (w_advance) begin
          if (r_pc < r_prog_len) begin
            w_fetch = 1'b1;
          end else begin
            w_finish     = 1'b1;
            w_state_next = DONE;
          end
        end
      end
      DONE: begin
      end
      default: w_state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= LOAD;
      r_wr_ptr    <= '0;
      r_pc        <= '0;
      r_prog_len  <= '0;
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_pc    <= '0;
      r_load_err  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_mem_we) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      // On overflow wr_ptr is DEPTH-1, so wr_ptr+1 is exactly DEPTH.
      if (w_load_end) begin
        r_prog_len <= {1'b0, r_wr_ptr} + (AW+1)'(1);
      end
      if (w_load_ovf) begin
        r_load_err <= 1'b1;
      end
      if (w_redirect) begin
        r_out_valid <= 1'b0;
        r_pc        <= {1'b0, redirect_pc};
      end else if (w_fetch) begin
        r_out_instr <= w_rdata;
        r_out_pc    <= r_pc[AW-1:0];
        r_out_valid <= 1'b1;
        r_pc        <= r_pc + (AW+1)'(1);
      end else if (w_finish) begin
        r_out_valid <= 1'b0;
        r_done      <= 1'b1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_pc    = r_out_pc;
  assign prog_len  = r_prog_len;
  assign load_err  = r_load_err;
  assign done      = r_done;
endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_fetch_stage                                          |
// | Brief    : Scoreboard bench for fetch_stage (DEPTH=256 and 4).     |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_fetch_stage;
  typedef struct {
    logic [31:0] instr;
    logic [8:0]  pc;
  } exp_t;

  logic        clk = 1'b0;
  int          checks = 0;
  int          failures = 0;

  // Main instance, DEPTH=256
  logic        rst, load_valid, load_last, load_ready, redirect_valid;
  logic [31:0] load_data, out_instr;
  logic [7:0]  redirect_pc, out_pc;
  logic        out_valid, out_ready, load_err, done;
  logic [8:0]  prog_len;

  // Small instance, DEPTH=4
  logic        rst4, load_valid4, load_last4, load_ready4, redirect_valid4;
  logic [31:0] load_data4, out_instr4;
  logic [1:0]  redirect_pc4, out_pc4;
  logic        out_valid4, out_ready4, load_err4, done4;
  logic [2:0]  prog_len4;

  exp_t q[$];
  exp_t q4[$];
  exp_t e, e4;

  always #5 clk = ~clk;

  fetch_stage #(.IW(32), .DEPTH(256), .AW(8)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready), .prog_len(prog_len), .load_err(load_err), .done(done)
  );

  fetch_stage #(.IW(32), .DEPTH(4), .AW(2)) dut4 (
    .clk(clk), .rst(rst4), .load_valid(load_valid4), .load_data(load_data4),
    .load_last(load_last4), .load_ready(load_ready4),
    .redirect_valid(redirect_valid4), .redirect_pc(redirect_pc4),
    .out_valid(out_valid4), .out_instr(out_instr4), .out_pc(out_pc4),
    .out_ready(out_ready4), .prog_len(prog_len4), .load_err(load_err4), .done(done4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [8:0] pc);
    exp_t x;
    x.instr = instr;
    x.pc    = pc;
    q.push_back(x);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic load_prog(input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3, input int n);
    logic [31:0] words [4];
    words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = words[i];
      load_last  = (i == n - 1);
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 30) begin
      tick();
      n++;
    end
    chk(name, done, 1'b1);
  endtask

  // Transfers happen when valid&ready and no redirect flushes that word.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && !redirect_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out actual pc=%0d instr=%0h required=none", out_pc, out_instr);
      end else begin
        e = q.pop_front();
        chk("out_instr", {32'd0, out_instr}, {32'd0, e.instr});
        chk("out_pc", {56'd0, out_pc}, {55'd0, e.pc});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst4 && out_valid4 && out_ready4 && !redirect_valid4) begin
      if (q4.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out4 actual pc=%0d instr=%0h required=none", out_pc4, out_instr4);
      end else begin
        e4 = q4.pop_front();
        chk("out_instr4", {32'd0, out_instr4}, {32'd0, e4.instr});
        chk("out_pc4", {62'd0, out_pc4}, {55'd0, e4.pc});
      end
    end
  end

  initial begin
    rst = 1'b1; load_valid = 0; load_data = '0; load_last = 0;
    redirect_valid = 0; redirect_pc = '0; out_ready = 0;
    rst4 = 1'b1; load_valid4 = 0; load_data4 = '0; load_last4 = 0;
    redirect_valid4 = 0; redirect_pc4 = '0; out_ready4 = 0;
    tick(); tick();

    chk("rst_load_ready", load_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_prog_len", prog_len, 9'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_load_err", load_err, 1'b0);
    chk("rst_out_pc", out_pc, 8'd0);
    chk("rst_out_instr", out_instr, 32'd0);

    // Straight run
    rst = 1'b0; out_ready = 1'b1;
    push(32'h11, 0); push(32'h22, 1); push(32'h33, 2); push(32'h44, 3);
    load_prog(32'h11, 32'h22, 32'h33, 32'h44, 4);
    chk("t1_prog_len", prog_len, 9'd4);
    chk("t1_load_ready", load_ready, 1'b0);
    tick(); tick(); tick(); tick();
    chk("t1_out_instr_last", out_instr, 32'h44);
    chk("t1_done_early", done, 1'b0);
    tick();
    chk("t1_done", done, 1'b1);
    chk("t1_out_valid_done", out_valid, 1'b0);
    chk("t1_q_empty", q.size(), 0);

    // Stall on 0x22
    do_reset();
    push(32'h11, 0); push(32'h22, 1); push(32'h33, 2); push(32'h44, 3);
    load_prog(32'h11, 32'h22, 32'h33, 32'h44, 4);
    tick(); tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_hold_instr", out_instr, 32'h22);
      chk("t2_hold_pc", out_pc, 8'd1);
      chk("t2_hold_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    wait_done("t2_done");
    chk("t2_q_empty", q.size(), 0);

    // Redirect to 0 while out_pc=2
    do_reset();
    push(32'h11, 0); push(32'h22, 1);
    push(32'h11, 0); push(32'h22, 1); push(32'h33, 2); push(32'h44, 3);
    load_prog(32'h11, 32'h22, 32'h33, 32'h44, 4);
    tick(); tick(); tick();
    chk("t3_setup_pc", out_pc, 8'd2);
    redirect_valid = 1'b1; redirect_pc = 8'd0;
    tick();
    redirect_valid = 1'b0;
    chk("t3_flush_valid", out_valid, 1'b0);
    tick();
    chk("t3_target_instr", out_instr, 32'h11);
    chk("t3_target_pc", out_pc, 8'd0);
    wait_done("t3_done");
    chk("t3_q_empty", q.size(), 0);

    // Redirect beyond the program end
    do_reset();
    push(32'h11, 0);
    load_prog(32'h11, 32'h22, 32'h33, 32'h44, 4);
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 8'd7;
    tick();
    redirect_valid = 1'b0;
    chk("t4_flush_valid", out_valid, 1'b0);
    tick();
    chk("t4_done", done, 1'b1);
    chk("t4_out_valid", out_valid, 1'b0);
    repeat (5) tick();
    chk("t4_still_idle", out_valid, 1'b0);
    chk("t4_q_empty", q.size(), 0);

    // Overflow on the DEPTH=4 instance
    rst4 = 1'b0; out_ready4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e4.instr = 32'hA1 + 32'(i);
      e4.pc    = 9'(i);
      q4.push_back(e4);
    end
    for (int i = 0; i < 6; i++) begin
      load_valid4 = 1'b1;
      load_data4  = 32'hA1 + 32'(i);
      tick();
    end
    load_valid4 = 1'b0;
    chk("t5_load_err", load_err4, 1'b1);
    chk("t5_prog_len", prog_len4, 3'd4);
    for (int n = 0; n < 30 && !done4; n++) tick();
    chk("t5_done", done4, 1'b1);
    chk("t5_q_empty", q4.size(), 0);

    // Reset mid-run, then reload
    do_reset();
    push(32'h11, 0); push(32'h22, 1);
    load_prog(32'h11, 32'h22, 32'h33, 32'h44, 4);
    tick(); tick(); tick();
    chk("t6_setup_pc", out_pc, 8'd2);
    rst = 1'b1;
    tick();
    chk("t6_load_ready", load_ready, 1'b1);
    chk("t6_out_valid", out_valid, 1'b0);
    chk("t6_done", done, 1'b0);
    chk("t6_prog_len", prog_len, 9'd0);
    rst = 1'b0;
    push(32'h55, 0); push(32'h66, 1);
    load_prog(32'h55, 32'h66, 32'h0, 32'h0, 2);
    chk("t6_reload_len", prog_len, 9'd2);
    wait_done("t6_reload_done");
    chk("t6_q_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
